// File: rtl/gate_bist_engine.sv
// rtl/gate_bist_engine.sv - self-test engine for a 2-input combinational gate
// Walks {a,b} through 00,01,10,11, samples y_in after a settle window, reports mismatches.
module gate_bist_engine #(
  parameter logic [3:0] EXP_TT        = 4'b1001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       err_valid,
  output logic [1:0] first_err_vec
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] settle_cnt;
  logic       mismatch;

  assign mismatch = (y_in != EXP_TT[vec]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vec           <= 2'd0;
      settle_cnt    <= 4'd0;
      a_out         <= 1'b0;
      b_out         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= 3'd0;
      err_valid     <= 1'b0;
      first_err_vec <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          // Previous results stay visible until the next accepted start.
          if (start) begin
            vec           <= 2'd0;
            a_out         <= 1'b0;
            b_out         <= 1'b0;
            err_cnt       <= 3'd0;
            err_valid     <= 1'b0;
            first_err_vec <= 2'd0;
            pass          <= 1'b0;
            busy          <= 1'b1;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 3'd1;
            if (!err_valid) begin
              err_valid     <= 1'b1;
              first_err_vec <= vec;
            end
          end
          if (vec != 2'd3) begin
            vec              <= vec + 2'd1;
            {a_out, b_out}   <= vec + 2'd1;
            state            <= DRIVE;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          pass  <= (err_cnt == 3'd0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
